writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter RSP_IDX, default 4'd5, stack-pointer register index.
REQ-002 Parameter RNONE, default 4'd15, "no register" index.
REQ-003 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 W_stall  input  1  hold W register.
REQ-006 W_bubble  input  1  load nop into W register.
REQ-007 M_stat  input  2  memory-stage status: 0 AOK, 1 HLT, 2 ADR, 3 INS.
REQ-008 M_icode  input  4  memory-stage icode.
REQ-009 M_cnd  input  1  condition flag carried with the instruction (cmovxx).
REQ-010 M_destE / M_destM  input  4 each  destination indices.
REQ-011 M_valE / m_valM  input  64 each  ALU result / memory read data.
REQ-012 W_icode, W_destE, W_destM, W_stat  output  4,4,4,2  W register contents (forwarding sources).
REQ-013 W_valE / W_valM  output  64 each  W register data (forwarding sources).
REQ-014 wrE_en, wrE_addr, wrE_data  output  1,4,64  register-file port E.
REQ-015 wrM_en, wrM_addr, wrM_data  output  1,4,64  register-file port M.
REQ-016 halted  output  1  sticky: processor stopped.
REQ-017 retire_cnt  output  32  instructions retired.

Function
REQ-018 W register loads M_* on rising clk when !W_stall && !W_bubble && !halted.
REQ-019 W_bubble (no stall) loads nop: icode 4'h1, destE=destM=RNONE, valE=valM=0, stat AOK.
REQ-020 W_stall holds every W field; stall has priority over simultaneous bubble.
REQ-021 On load, M_icode==4'h2 && !M_cnd captures destE as RNONE (untaken cmov writes nothing).
REQ-022 Write ports are combinational from the W register: wrE_addr=W_destE, wrE_data=W_valE, wrM_addr=W_destM, wrM_data=W_valM.
REQ-023 wrE_en = (W_destE!=RNONE) && W_stat==AOK && !halted; wrM_en likewise on W_destM.
REQ-024 If W_destE==W_destM and both enabled, wrE_en SHALL be 0 (port M wins; popq %rsp loads memory value).
REQ-025 halted sets on the rising edge after W_stat!=AOK is held; once set, W register freezes, both write enables 0, until reset.
REQ-026 retire_cnt increments by 1 each edge a non-bubble W_icode (!=4'h1) with W_stat==AOK leaves W (next W load occurs and !halted); wraps 0xFFFFFFFF->0.
REQ-027 Stalled cycles SHALL not increment retire_cnt; the held instruction counts once when it leaves.
REQ-028 Latency: M inputs appear on W outputs and write ports one clk after capture.

Reset
REQ-029 reset asserted at rising edge: W register = nop (REQ-019), halted=0, retire_cnt=0; overrides stall, bubble and halted.
REQ-030 Reset mid-stall or after halt returns to running state on the next edge with reset low.
REQ-031 During reset cycle outputs reflect reset values one edge later; wrE_en=wrM_en=0 after reset.

Configuration
REQ-032 Macro WB_RETIRE_CNT_EN: defined -> retire counter per REQ-026/027; undefined -> no counter logic, retire_cnt tied to 32'd0.

Verification
REQ-033 Reset, then M_icode=6,M_destE=3,M_valE=0x2A,stat AOK -> next cycle wrE_en=1, wrE_addr=3, wrE_data=0x2A, retire_cnt=0 then 1 after next load.
REQ-034 cmov M_icode=2,M_cnd=0,M_destE=7 -> W_destE=15, wrE_en=0; with M_cnd=1 -> wrE_addr=7.
REQ-035 popq M_icode=0xB, destE=5,destM=5, valE=0x100, valM=0x55 -> wrM_en=1 data 0x55, wrE_en=0.
REQ-036 W_stall=1 and W_bubble=1 for 3 cycles with new M inputs -> W fields unchanged, retire_cnt unchanged.
REQ-037 M_stat=1 (HLT) loaded -> W_stat=1, halted=1 next edge, later M inputs ignored, write enables 0; reset clears halted.
REQ-038 Counter preloaded to 0xFFFFFFFF by 2^32-1 retirements (forced) + one retirement -> retire_cnt=0; macro undefined -> stays 0.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage: W pipeline register, register-file write ports, sticky halt
// detection and an optional retired-instruction counter.
// Optional feature macro: WB_RETIRE_CNT_EN (defined -> retire counter present,
// undefined -> retire_cnt tied to zero).
module writeback_stage #(
    parameter logic [3:0] RSP_IDX = 4'd5,
    parameter logic [3:0] RNONE   = 4'd15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        W_stall,
    input  logic        W_bubble,
    input  logic [1:0]  M_stat,
    input  logic [3:0]  M_icode,
    input  logic        M_cnd,
    input  logic [3:0]  M_destE,
    input  logic [3:0]  M_destM,
    input  logic [63:0] M_valE,
    input  logic [63:0] m_valM,
    output logic [3:0]  W_icode,
    output logic [3:0]  W_destE,
    output logic [3:0]  W_destM,
    output logic [1:0]  W_stat,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic        wrE_en,
    output logic [3:0]  wrE_addr,
    output logic [63:0] wrE_data,
    output logic        wrM_en,
    output logic [3:0]  wrM_addr,
    output logic [63:0] wrM_data,
    output logic        halted,
    output logic [31:0] retire_cnt
);

    localparam int unsigned REG_W  = 4;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STAT_W = 2;
    localparam int unsigned CNT_W  = 32;

    localparam logic [STAT_W-1:0] STAT_AOK   = STAT_W'(0);
    localparam logic [REG_W-1:0]  ICODE_NOP  = REG_W'(4'h1);
    localparam logic [REG_W-1:0]  ICODE_CMOV = REG_W'(4'h2);

    typedef struct packed {
        logic [REG_W-1:0]  icode;
        logic [STAT_W-1:0] stat;
        logic [REG_W-1:0]  dest_e;
        logic [REG_W-1:0]  dest_m;
        logic [DATA_W-1:0] val_e;
        logic [DATA_W-1:0] val_m;
    } w_reg_t;

    w_reg_t w_q, w_d, nop_c;
    logic   halted_q, halted_d;
    logic   freeze_c;
    logic   advance_c;
    logic   e_ok_c, m_ok_c;
    logic   unused_sp_c;

    // Stack-pointer index is informational here; port M priority covers popq %rsp.
    assign unused_sp_c = (w_q.dest_m == RSP_IDX);

    // Next W register contents and halt flag.
    always_comb begin
        nop_c        = '0;
        nop_c.icode  = ICODE_NOP;
        nop_c.stat   = STAT_AOK;
        nop_c.dest_e = RNONE;
        nop_c.dest_m = RNONE;

        w_d       = w_q;
        // A non-AOK instruction in W stays put so its status remains visible.
        freeze_c  = halted_q || (w_q.stat != STAT_AOK);
        advance_c = !W_stall && !freeze_c;

        if (advance_c) begin
            if (W_bubble) begin
                w_d = nop_c;
            end else begin
                w_d.icode  = M_icode;
                w_d.stat   = M_stat;
                w_d.dest_e = (M_icode == ICODE_CMOV && !M_cnd) ? RNONE : M_destE;
                w_d.dest_m = M_destM;
                w_d.val_e  = M_valE;
                w_d.val_m  = m_valM;
            end
        end

        halted_d = halted_q || (w_q.stat != STAT_AOK);
    end

    // W register and halt flag state update.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_q      <= nop_c;
            halted_q <= 1'b0;
        end else begin
            w_q      <= w_d;
            halted_q <= halted_d;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_q, retire_d;

    // Count a real, AOK instruction each time it is replaced in W.
    always_comb begin
        retire_d = retire_q;
        if (advance_c && w_q.icode != ICODE_NOP && w_q.stat == STAT_AOK) begin
            retire_d = retire_q + CNT_W'(1);
        end
    end

    // Retire counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign retire_cnt = retire_q;
`else
    assign retire_cnt = CNT_W'(0);
`endif

    // Write-port enables; port M wins when both target the same register.
    always_comb begin
        e_ok_c = (w_q.dest_e != RNONE) && (w_q.stat == STAT_AOK) && !halted_q;
        m_ok_c = (w_q.dest_m != RNONE) && (w_q.stat == STAT_AOK) && !halted_q;
        wrM_en = m_ok_c;
        wrE_en = e_ok_c && !(m_ok_c && (w_q.dest_e == w_q.dest_m));
    end

    assign W_icode  = w_q.icode;
    assign W_destE  = w_q.dest_e;
    assign W_destM  = w_q.dest_m;
    assign W_stat   = w_q.stat;
    assign W_valE   = w_q.val_e;
    assign W_valM   = w_q.val_m;
    assign wrE_addr = w_q.dest_e;
    assign wrE_data = w_q.val_e;
    assign wrM_addr = w_q.dest_m;
    assign wrM_data = w_q.val_m;
    assign halted   = halted_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed testbench for writeback_stage with hand-computed expectations.
module tb_writeback_stage;

    logic        clk;
    logic        reset;
    logic        W_stall;
    logic        W_bubble;
    logic [1:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [3:0]  M_destE;
    logic [3:0]  M_destM;
    logic [63:0] M_valE;
    logic [63:0] m_valM;
    logic [3:0]  W_icode;
    logic [3:0]  W_destE;
    logic [3:0]  W_destM;
    logic [1:0]  W_stat;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic        wrE_en;
    logic [3:0]  wrE_addr;
    logic [63:0] wrE_data;
    logic        wrM_en;
    logic [3:0]  wrM_addr;
    logic [63:0] wrM_data;
    logic        halted;
    logic [31:0] retire_cnt;

    int n_cmp;
    int n_bad;

    writeback_stage dut (
        .clk       (clk),
        .reset     (reset),
        .W_stall   (W_stall),
        .W_bubble  (W_bubble),
        .M_stat    (M_stat),
        .M_icode   (M_icode),
        .M_cnd     (M_cnd),
        .M_destE   (M_destE),
        .M_destM   (M_destM),
        .M_valE    (M_valE),
        .m_valM    (m_valM),
        .W_icode   (W_icode),
        .W_destE   (W_destE),
        .W_destM   (W_destM),
        .W_stat    (W_stat),
        .W_valE    (W_valE),
        .W_valM    (W_valM),
        .wrE_en    (wrE_en),
        .wrE_addr  (wrE_addr),
        .wrE_data  (wrE_data),
        .wrM_en    (wrM_en),
        .wrM_addr  (wrM_addr),
        .wrM_data  (wrM_data),
        .halted    (halted),
        .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected counter value: the count when the counter is built, else zero.
    function automatic logic [63:0] rc(input int n);
`ifdef WB_RETIRE_CNT_EN
        return 64'(n);
`else
        return 64'(n * 0);
`endif
    endfunction

    task automatic drive_m(input logic [3:0] icode, input logic [1:0] stat, input logic cnd,
                           input logic [3:0] de, input logic [3:0] dm,
                           input logic [63:0] ve, input logic [63:0] vm);
        M_icode = icode;
        M_stat  = stat;
        M_cnd   = cnd;
        M_destE = de;
        M_destM = dm;
        M_valE  = ve;
        m_valM  = vm;
    endtask

    // One rising edge, then settle at the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        reset    = 1'b1;
        W_stall  = 1'b0;
        W_bubble = 1'b0;
        drive_m(4'h1, 2'd0, 1'b0, 4'd15, 4'd15, 64'h0, 64'h0);
        @(negedge clk);
        step();
        reset = 1'b0;

        chk("rst_icode",  64'(W_icode), 64'h1);
        chk("rst_destE",  64'(W_destE), 64'd15);
        chk("rst_destM",  64'(W_destM), 64'd15);
        chk("rst_stat",   64'(W_stat), 64'd0);
        chk("rst_wrE_en", 64'(wrE_en), 64'd0);
        chk("rst_wrM_en", 64'(wrM_en), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_retire", 64'(retire_cnt), rc(0));

        // Simple ALU result write on port E.
        drive_m(4'h6, 2'd0, 1'b0, 4'd3, 4'd15, 64'h2A, 64'h0);
        step();
        chk("alu_wrE_en",   64'(wrE_en), 64'd1);
        chk("alu_wrE_addr", 64'(wrE_addr), 64'd3);
        chk("alu_wrE_data", wrE_data, 64'h2A);
        chk("alu_wrM_en",   64'(wrM_en), 64'd0);
        chk("alu_retire",   64'(retire_cnt), rc(0));

        // Untaken cmov: destination squashed to RNONE.
        drive_m(4'h2, 2'd0, 1'b0, 4'd7, 4'd15, 64'h11, 64'h0);
        step();
        chk("cmov0_destE",  64'(W_destE), 64'd15);
        chk("cmov0_wrE_en", 64'(wrE_en), 64'd0);
        chk("cmov0_retire", 64'(retire_cnt), rc(1));

        // Taken cmov writes its destination.
        drive_m(4'h2, 2'd0, 1'b1, 4'd7, 4'd15, 64'h22, 64'h0);
        step();
        chk("cmov1_wrE_en",   64'(wrE_en), 64'd1);
        chk("cmov1_wrE_addr", 64'(wrE_addr), 64'd7);
        chk("cmov1_retire",   64'(retire_cnt), rc(2));

        // popq %rsp: both ports target 5, port M wins.
        drive_m(4'hB, 2'd0, 1'b0, 4'd5, 4'd5, 64'h100, 64'h55);
        step();
        chk("pop_wrM_en",   64'(wrM_en), 64'd1);
        chk("pop_wrM_addr", 64'(wrM_addr), 64'd5);
        chk("pop_wrM_data", wrM_data, 64'h55);
        chk("pop_wrE_en",   64'(wrE_en), 64'd0);
        chk("pop_retire",   64'(retire_cnt), rc(3));

        // Stall with simultaneous bubble holds everything for 3 cycles.
        W_stall  = 1'b1;
        W_bubble = 1'b1;
        drive_m(4'h6, 2'd0, 1'b0, 4'd9, 4'd15, 64'h77, 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_icode",  64'(W_icode), 64'hB);
            chk("stall_destE",  64'(W_destE), 64'd5);
            chk("stall_valM",   W_valM, 64'h55);
            chk("stall_retire", 64'(retire_cnt), rc(3));
        end

        // Bubble alone: popq leaves (counts), nop enters.
        W_stall = 1'b0;
        step();
        chk("bub_icode",  64'(W_icode), 64'h1);
        chk("bub_destE",  64'(W_destE), 64'd15);
        chk("bub_destM",  64'(W_destM), 64'd15);
        chk("bub_wrE_en", 64'(wrE_en), 64'd0);
        chk("bub_wrM_en", 64'(wrM_en), 64'd0);
        chk("bub_retire", 64'(retire_cnt), rc(4));

        // Bubble leaving does not count.
        W_bubble = 1'b0;
        drive_m(4'h6, 2'd0, 1'b0, 4'd4, 4'd15, 64'h99, 64'h0);
        step();
        chk("post_bub_wrE_en", 64'(wrE_en), 64'd1);
        chk("post_bub_data",   wrE_data, 64'h99);
        chk("post_bub_retire", 64'(retire_cnt), rc(4));

        // HLT enters W.
        drive_m(4'h0, 2'd1, 1'b0, 4'd15, 4'd15, 64'h0, 64'h0);
        step();
        chk("hlt_stat",   64'(W_stat), 64'd1);
        chk("hlt_halted", 64'(halted), 64'd0);
        chk("hlt_wrE_en", 64'(wrE_en), 64'd0);
        chk("hlt_retire", 64'(retire_cnt), rc(5));

        // Halt sets next edge; later inputs ignored.
        drive_m(4'h6, 2'd0, 1'b0, 4'd2, 4'd2, 64'h33, 64'h44);
        step();
        chk("halt_halted", 64'(halted), 64'd1);
        chk("halt_stat",   64'(W_stat), 64'd1);
        chk("halt_icode",  64'(W_icode), 64'h0);
        chk("halt_wrE_en", 64'(wrE_en), 64'd0);
        chk("halt_wrM_en", 64'(wrM_en), 64'd0);
        step();
        chk("halt2_halted", 64'(halted), 64'd1);
        chk("halt2_destE",  64'(W_destE), 64'd15);
        chk("halt2_retire", 64'(retire_cnt), rc(5));

        // Reset clears halt and returns to running.
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_halted", 64'(halted), 64'd0);
        chk("rst2_icode",  64'(W_icode), 64'h1);
        chk("rst2_stat",   64'(W_stat), 64'd0);
        chk("rst2_retire", 64'(retire_cnt), rc(0));
        step();
        chk("run_wrE_en",  64'(wrE_en), 64'd0);
        chk("run_wrM_en",  64'(wrM_en), 64'd1);
        chk("run_wrM_data", wrM_data, 64'h44);
        chk("run_icode",   64'(W_icode), 64'h6);

`ifdef WB_RETIRE_CNT_EN
        // Counter wrap: preload all-ones, then one retirement.
        force dut.retire_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_q;
        drive_m(4'h6, 2'd0, 1'b0, 4'd1, 4'd15, 64'h5, 64'h0);
        step();
        chk("wrap_retire", 64'(retire_cnt), 64'h0);
`else
        drive_m(4'h6, 2'd0, 1'b0, 4'd1, 4'd15, 64'h5, 64'h0);
        step();
        chk("nocnt_retire", 64'(retire_cnt), rc(1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
